timer_ctrl_master: RTL and testbench
====================================

Name: timer_ctrl_master

Overview:
- Avalon-MM initiator that drives the 16-bit interval-timer slave (3-bit word address, no waitrequest, registered readdata, fixed read latency 1).
- Lets accelerator logic run hardware one-shot delays and take timer snapshots without Nios II involvement.
- Accepts one command at a time on a valid/ready port and returns one response pulse per command.

Parameters:
- POLL_GAP, 4, idle cycles between status polls (0..255).
- MAX_POLLS, 65535, poll watchdog limit (16-bit poll counter).
- ITO_EN, 0, value written to control bit0 (interrupt enable) on start.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = DELAY (program period, start one-shot, wait for timeout); 1 = SNAPSHOT.
- cmd_period  in  32  DELAY period value; ignored for SNAPSHOT.
- abort  in  1  pulse; cancels a busy command.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_status  out  2  0 OK, 1 WATCHDOG, 2 ABORTED.
- rsp_data  out  32  snapshot value (SNAPSHOT) or poll count, zero-extended (DELAY).
- avm_address  out  3  slave word address.
- avm_chipselect  out  1  slave select.
- avm_write_n  out  1  active-low write.
- avm_writedata  out  16  write data.
- avm_readdata  in  16  slave read data.

Behaviour:
- Slave register map (word offsets):
  - 0 status: bit0 TO, bit1 RUN; any write clears TO.
  - 1 control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - 2 period_l, 3 period_h.
  - 4 snap_l, 5 snap_h; a write to either captures the counter.
- Reset values: cmd_ready 1, rsp_valid 0, rsp_status 0, rsp_data 0, avm_chipselect 0, avm_write_n 1, avm_address 0, avm_writedata 0. State IDLE, poll counter 0, abort_pending 0.
- Bus timing:
  - Write: exactly one cycle with chipselect=1, write_n=0.
  - Read: one cycle with chipselect=1, write_n=1, address=A. avm_readdata is sampled in the following cycle.
  - Outside bus cycles, chipselect=0 and write_n=1.
- Accept: cmd_valid && cmd_ready at a clock edge. Command fields are latched. abort is ignored in IDLE.
- DELAY sequence:
  - WR_PL (addr 2, cmd_period[15:0]) -> WR_PH (addr 3, cmd_period[31:16]) -> WR_CTRL (addr 1, data {12'b0,0,1,0,ITO_EN}).
  - Then GAP (POLL_GAP cycles) -> RD_A (addr 0) -> RD_C (sample). Each RD_C increments the poll counter.
  - If sampled bit0=1 -> CLR (write addr 0, data 0) -> DONE, status OK.
  - Otherwise, if poll count == MAX_POLLS -> STOP (write addr 1, data 0x0008) -> DONE, status WATCHDOG. Otherwise -> GAP.
- DELAY with cmd_period==0: no bus traffic. Goes straight to DONE with status OK and rsp_data 0; rsp_valid fires the cycle after accept.
- SNAPSHOT sequence:
  - SNAP_W (write addr 4, data 0) -> RDL_A (addr 4) -> RDL_C (latch low half) -> RDH_A (addr 5) -> RDH_C (latch high half) -> DONE, status OK.
  - rsp_data = {high, low}.
- DONE: rsp_valid=1 for one cycle, then IDLE with cmd_ready=1. A new command can be accepted on the cycle after DONE. rsp_* hold their values until the next DONE.
- Abort:
  - An abort pulse while busy sets abort_pending.
  - It is acted on at the next state boundary; the current single-cycle bus access always completes.
  - Path: STOP write (0x0008) -> DONE, status ABORTED.
  - An abort arriving in DONE or in the STOP state is dropped.
  - If abort and a timeout detection land in the same RD_C, ABORTED wins and CLR is skipped.
- Poll counter: 16 bits, saturates at MAX_POLLS, never wraps. It is cleared on command accept.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). No STOP write is issued.

Decomposition:
- Shared package timer_ctrl_pkg:
  - register offsets (REG_STATUS..REG_SNAPH);
  - control bit indices;
  - opcode constants OP_DELAY/OP_SNAP;
  - status codes RSP_OK/RSP_WDOG/RSP_ABORT;
  - state enum.
- Single module; no sub-module needed. The FSM plus the gap and poll counters stay in one block.

Test Plan:
- DELAY, period 100, POLL_GAP 4, connected to the timer slave model -> bus sequence addr2=0x0064, addr3=0x0000, addr1=0x0004. Polls repeat until TO is seen, then a write addr0=0. rsp_status 0; rsp_data equals the observed poll count (>0).
- SNAPSHOT with the slave counter frozen at 0x00AB_CDEF -> write addr4, reads addr4 then addr5. rsp_data 0x00ABCDEF, rsp_status 0, total latency 6 cycles after accept.
- DELAY, period 0x0001_0000, MAX_POLLS 3, slave TO held at 0 -> exactly 3 reads of addr0, then a write addr1=0x0008. rsp_status 1, rsp_data 3.
- DELAY, period 1000; abort pulsed during the 2nd GAP -> the current cycle completes, then a write addr1=0x0008. rsp_status 2, no write to addr0.
- DELAY with cmd_period 0 -> no chipselect assertion; rsp_valid 1 cycle after accept, status 0, data 0.
- reset asserted during WR_CTRL -> chipselect drops asynchronously, cmd_ready 1, rsp_valid 0. A following SNAPSHOT completes normally.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the interval-timer control master: slave register
// word offsets, control bit positions, command opcodes, response status codes
// and the controller state encoding.
package timer_ctrl_pkg;

  // Interval-timer slave word offsets
  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_PERL   = 3'd2;
  localparam logic [2:0] REG_PERH   = 3'd3;
  localparam logic [2:0] REG_SNAPL  = 3'd4;
  localparam logic [2:0] REG_SNAPH  = 3'd5;

  // Control register bit indices
  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  // Status register bit indices
  localparam int unsigned STAT_TO  = 0;
  localparam int unsigned STAT_RUN = 1;

  // Command opcodes
  localparam logic OP_DELAY = 1'b0;
  localparam logic OP_SNAP  = 1'b1;

  // Response status codes
  localparam logic [1:0] RSP_OK    = 2'd0;
  localparam logic [1:0] RSP_WDOG  = 2'd1;
  localparam logic [1:0] RSP_ABORT = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_GAP,
    S_RD_A,
    S_RD_C,
    S_CLR,
    S_STOP,
    S_SNAP_W,
    S_RDL_A,
    S_RDL_C,
    S_RDH_A,
    S_RDH_C,
    S_DONE
  } state_e;

endpackage

// File: rtl/timer_ctrl_master_if.sv
// Avalon-MM bus between the timer control master and the 16-bit
// interval-timer slave (no waitrequest, registered readdata, latency 1).
//   avm_address    3-bit word address
//   avm_chipselect slave select
//   avm_write_n    active-low write strobe
//   avm_writedata  16-bit write data
//   avm_readdata   16-bit read data (valid the cycle after the read)
interface timer_ctrl_master_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/timer_ctrl_master.sv
// Avalon-MM initiator running one-shot delays and counter snapshots on the
// interval-timer slave, one command at a time.
//   clk, reset       clock, asynchronous active-high reset
//   cmd_valid/ready  command handshake (ready only when idle)
//   cmd_op           0 = DELAY, 1 = SNAPSHOT
//   cmd_period       DELAY period (0 = complete immediately, no bus traffic)
//   abort            pulse; cancels a busy command via a timer STOP write
//   rsp_valid        one-cycle response pulse
//   rsp_status       0 OK, 1 WATCHDOG, 2 ABORTED (held until next response)
//   rsp_data         snapshot value or poll count (held until next response)
//   avm              Avalon-MM master port to the timer slave
module timer_ctrl_master
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned MAX_POLLS = 65535,
  parameter bit          ITO_EN    = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [31:0]                cmd_period,
  input  logic                       abort,
  output logic                       rsp_valid,
  output logic [1:0]                 rsp_status,
  output logic [31:0]                rsp_data,
  timer_ctrl_master_if.master        avm
);

  localparam logic [15:0] MAX_CNT    = 16'(MAX_POLLS);
  localparam logic [7:0]  GAP_LAST   = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);
  localparam logic [15:0] START_WORD = 16'((1 << CTRL_START) | (ITO_EN ? (1 << CTRL_ITO) : 0));
  localparam logic [15:0] STOP_WORD  = 16'(1 << CTRL_STOP);
  localparam state_e      POLL_ENTRY = (POLL_GAP == 0) ? S_RD_A : S_GAP;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [31:0] period_q, period_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] poll_q, poll_d;
  logic        abort_pend_q, abort_pend_d;
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic        cs, wr_n;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic        abort_now;
  logic [15:0] poll_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_DELAY;
      period_q     <= '0;
      gap_q        <= '0;
      poll_q       <= '0;
      abort_pend_q <= 1'b0;
      snap_lo_q    <= '0;
      rsp_status_q <= RSP_OK;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      period_q     <= period_d;
      gap_q        <= gap_d;
      poll_q       <= poll_d;
      abort_pend_q <= abort_pend_d;
      snap_lo_q    <= snap_lo_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    period_d     = period_q;
    gap_d        = gap_q;
    poll_d       = poll_q;
    abort_pend_d = abort_pend_q;
    snap_lo_d    = snap_lo_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    cs           = 1'b0;
    wr_n         = 1'b1;
    addr         = '0;
    wdata        = '0;

    // Every busy state lasts one cycle (GAP re-evaluates each cycle), so an
    // abort seen this cycle or earlier is acted on at this cycle's edge.
    // abort_pend_q also remembers why STOP was entered.
    abort_now = abort_pend_q | abort;
    poll_inc  = (poll_q == MAX_CNT) ? poll_q : poll_q + 16'd1;

    if (abort && state_q != S_IDLE && state_q != S_STOP && state_q != S_DONE)
      abort_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d         = cmd_op;
          period_d     = cmd_period;
          poll_d       = '0;
          gap_d        = '0;
          abort_pend_d = 1'b0;
          if (cmd_op == OP_SNAP) begin
            state_d = S_SNAP_W;
          end else if (cmd_period == '0) begin
            state_d      = S_DONE;
            rsp_status_d = RSP_OK;
            rsp_data_d   = '0;
          end else begin
            state_d = S_WR_PL;
          end
        end
      end
      S_WR_PL: begin
        cs = 1'b1; wr_n = 1'b0; addr = REG_PERL; wdata = period_q[15:0];
        state_d = abort_now ? S_STOP : S_WR_PH;
      end
      S_WR_PH: begin
        cs = 1'b1; wr_n = 1'b0; addr = REG_PERH; wdata = period_q[31:16];
        state_d = abort_now ? S_STOP : S_WR_CTRL;
      end
      S_WR_CTRL: begin
        cs = 1'b1; wr_n = 1'b0; addr = REG_CTRL; wdata = START_WORD;
        gap_d   = '0;
        state_d = abort_now ? S_STOP : POLL_ENTRY;
      end
      S_GAP: begin
        if (abort_now) begin
          state_d = S_STOP;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_RD_A;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_RD_A: begin
        cs = 1'b1; addr = REG_STATUS;
        state_d = abort_now ? S_STOP : S_RD_C;
      end
      S_RD_C: begin
        poll_d = poll_inc;
        gap_d  = '0;
        if (abort_now)                   state_d = S_STOP;
        else if (avm.avm_readdata[STAT_TO]) state_d = S_CLR;
        else if (poll_inc == MAX_CNT)    state_d = S_STOP;
        else                             state_d = POLL_ENTRY;
      end
      S_CLR: begin
        cs = 1'b1; wr_n = 1'b0; addr = REG_STATUS;
        if (abort_now) begin
          state_d = S_STOP;
        end else begin
          state_d      = S_DONE;
          rsp_status_d = RSP_OK;
          rsp_data_d   = {16'h0000, poll_q};
        end
      end
      S_STOP: begin
        cs = 1'b1; wr_n = 1'b0; addr = REG_CTRL; wdata = STOP_WORD;
        state_d      = S_DONE;
        rsp_status_d = abort_pend_q ? RSP_ABORT : RSP_WDOG;
        rsp_data_d   = (op_q == OP_DELAY) ? {16'h0000, poll_q} : '0;
      end
      S_SNAP_W: begin
        cs = 1'b1; wr_n = 1'b0; addr = REG_SNAPL;
        state_d = abort_now ? S_STOP : S_RDL_A;
      end
      S_RDL_A: begin
        cs = 1'b1; addr = REG_SNAPL;
        state_d = abort_now ? S_STOP : S_RDL_C;
      end
      S_RDL_C: begin
        snap_lo_d = avm.avm_readdata;
        state_d   = abort_now ? S_STOP : S_RDH_A;
      end
      S_RDH_A: begin
        cs = 1'b1; addr = REG_SNAPH;
        state_d = abort_now ? S_STOP : S_RDH_C;
      end
      S_RDH_C: begin
        if (abort_now) begin
          state_d = S_STOP;
        end else begin
          state_d      = S_DONE;
          rsp_status_d = RSP_OK;
          rsp_data_d   = {avm.avm_readdata, snap_lo_q};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready          = (state_q == S_IDLE);
  assign rsp_valid          = (state_q == S_DONE);
  assign rsp_status         = rsp_status_q;
  assign rsp_data           = rsp_data_q;
  assign avm.avm_chipselect = cs;
  assign avm.avm_write_n    = wr_n;
  assign avm.avm_address    = addr;
  assign avm.avm_writedata  = wdata;

endmodule

// File: tb/tb_timer_ctrl_master.sv
module tb_timer_ctrl_master;
  import timer_ctrl_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- main DUT (default watchdog) with timer slave model
  timer_ctrl_master_if bus();
  logic        cmd_valid, cmd_ready, cmd_op, abort, rsp_valid;
  logic [31:0] cmd_period, rsp_data;
  logic [1:0]  rsp_status;

  timer_ctrl_master #(.POLL_GAP(4), .MAX_POLLS(65535), .ITO_EN(1'b0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .abort(abort),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .avm(bus)
  );

  // ---------------- watchdog DUT; its slave never reports timeout
  timer_ctrl_master_if bus_wd();
  logic        wd_cmd_valid, wd_cmd_ready, wd_cmd_op, wd_abort, wd_rsp_valid;
  logic [31:0] wd_cmd_period, wd_rsp_data;
  logic [1:0]  wd_rsp_status;

  timer_ctrl_master #(.POLL_GAP(4), .MAX_POLLS(3), .ITO_EN(1'b0)) dut_wd (
    .clk(clk), .reset(reset), .cmd_valid(wd_cmd_valid), .cmd_ready(wd_cmd_ready),
    .cmd_op(wd_cmd_op), .cmd_period(wd_cmd_period), .abort(wd_abort),
    .rsp_valid(wd_rsp_valid), .rsp_status(wd_rsp_status), .rsp_data(wd_rsp_data),
    .avm(bus_wd)
  );
  assign bus_wd.avm_readdata = 16'h0000;

  // ---------------- interval timer slave model
  logic        frozen = 1'b0;
  logic [15:0] sl_per_l, sl_per_h, sl_rd_q;
  logic [31:0] sl_cnt, sl_snap;
  logic        sl_run, sl_to;
  assign bus.avm_readdata = sl_rd_q;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sl_per_l <= '0; sl_per_h <= '0; sl_rd_q <= '0;
      sl_cnt <= '0; sl_snap <= '0; sl_run <= 1'b0; sl_to <= 1'b0;
    end else begin
      if (sl_run) begin
        if (sl_cnt == 0) begin sl_to <= 1'b1; sl_run <= 1'b0; end
        else sl_cnt <= sl_cnt - 1;
      end
      if (bus.avm_chipselect && !bus.avm_write_n) begin
        case (bus.avm_address)
          3'd0: sl_to <= 1'b0;
          3'd1: begin
            if (bus.avm_writedata[2]) begin sl_cnt <= {sl_per_h, sl_per_l}; sl_run <= 1'b1; end
            if (bus.avm_writedata[3]) sl_run <= 1'b0;
          end
          3'd2: sl_per_l <= bus.avm_writedata;
          3'd3: sl_per_h <= bus.avm_writedata;
          3'd4, 3'd5: sl_snap <= frozen ? 32'h00AB_CDEF : sl_cnt;
          default: ;
        endcase
      end
      if (bus.avm_chipselect && bus.avm_write_n) begin
        case (bus.avm_address)
          3'd0: sl_rd_q <= {14'b0, sl_run, sl_to};
          3'd4: sl_rd_q <= sl_snap[15:0];
          3'd5: sl_rd_q <= sl_snap[31:16];
          default: sl_rd_q <= 16'h0000;
        endcase
      end
    end
  end

  // ---------------- bus monitors and scoreboard queues
  txn_t obs_q[$], obs_wd_q[$], exp_q[$];
  logic rsp_exp_q[$];

  always @(posedge clk) begin
    if (bus.avm_chipselect)
      obs_q.push_back({!bus.avm_write_n, bus.avm_address,
                       bus.avm_write_n ? 16'h0000 : bus.avm_writedata});
    if (bus_wd.avm_chipselect)
      obs_wd_q.push_back({!bus_wd.avm_write_n, bus_wd.avm_address,
                          bus_wd.avm_write_n ? 16'h0000 : bus_wd.avm_writedata});
  end

  function automatic txn_t wr_t(input logic [2:0] a, input logic [15:0] d);
    return {1'b1, a, d};
  endfunction
  function automatic txn_t rd_t(input logic [2:0] a);
    return {1'b0, a, 16'h0000};
  endfunction

  // Issue one command; returns at the negedge of the first cycle after accept.
  task automatic send(input logic op, input logic [31:0] per);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_period = per;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; cyc counts cycles after accept.
  task automatic wait_rsp(input int limit, output int cyc);
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_status, rsp_data} !== {1'b1, 1'b0, 2'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_cmdrsp got=%h exp=%h", {cmd_ready, rsp_valid, rsp_status, rsp_data},
               {1'b1, 1'b0, 2'd0, 32'd0});
    end
    checks++;
    if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata} !==
        {1'b0, 1'b1, 3'd0, 16'd0}) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=%h",
               {bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata},
               {1'b0, 1'b1, 3'd0, 16'd0});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_delay();
    int cyc, n_reads;
    txn_t o, e;
    obs_q.delete();
    exp_q.push_back(wr_t(3'd2, 16'h0064));
    exp_q.push_back(wr_t(3'd3, 16'h0000));
    exp_q.push_back(wr_t(3'd1, 16'h0004));
    send(OP_DELAY, 32'd100);
    wait_rsp(2000, cyc);
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++; $display("FAIL delay_timeout got=%b exp=1", rsp_valid);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin failures++; $display("FAIL delay_setup got=%h exp=%h", o, e); end
    end
    n_reads = 0;
    while (obs_q.size() > 1) begin
      o = obs_q.pop_front();
      n_reads++;
      if (o !== rd_t(3'd0)) begin
        checks++; failures++;
        $display("FAIL delay_poll got=%h exp=%h", o, rd_t(3'd0));
      end
    end
    o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
    checks++;
    if (o !== wr_t(3'd0, 16'h0000)) begin
      failures++; $display("FAIL delay_clr got=%h exp=%h", o, wr_t(3'd0, 16'h0000));
    end
    checks++;
    if (rsp_status !== RSP_OK || rsp_data !== 32'(n_reads) || n_reads == 0) begin
      failures++;
      $display("FAIL delay_rsp got=%0d/%0d exp=0/%0d (reads>0)", rsp_status, rsp_data, n_reads);
    end
    @(negedge clk);
  endtask

  task automatic test_snapshot();
    int cyc;
    txn_t o, e;
    frozen = 1'b1;
    obs_q.delete();
    exp_q.push_back(wr_t(3'd4, 16'h0000));
    exp_q.push_back(rd_t(3'd4));
    exp_q.push_back(rd_t(3'd5));
    send(OP_SNAP, 32'hFFFF_FFFF);
    wait_rsp(50, cyc);
    checks++;
    if (rsp_valid !== 1'b1 || cyc != 6) begin
      failures++; $display("FAIL snap_latency got=%0d exp=6 (valid=%b)", cyc, rsp_valid);
    end
    checks++;
    if (rsp_data !== 32'h00AB_CDEF || rsp_status !== RSP_OK) begin
      failures++; $display("FAIL snap_rsp got=%h/%0d exp=00abcdef/0", rsp_data, rsp_status);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin failures++; $display("FAIL snap_bus got=%h exp=%h", o, e); end
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, rsp_data} !== {1'b0, 1'b1, 32'h00AB_CDEF}) begin
      failures++;
      $display("FAIL snap_hold got=%h exp=%h", {rsp_valid, cmd_ready, rsp_data},
               {1'b0, 1'b1, 32'h00AB_CDEF});
    end
  endtask

  task automatic test_period_zero();
    obs_q.delete();
    send(OP_DELAY, 32'd0);
    checks++;
    if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, RSP_OK, 32'd0}) begin
      failures++;
      $display("FAIL zero_rsp got=%h exp=%h", {rsp_valid, rsp_status, rsp_data}, {1'b1, RSP_OK, 32'd0});
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL zero_nobus got=%b%b/%0d exp=01/0", rsp_valid, cmd_ready, obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    rsp_exp_q.push_back(1'b1);
    rsp_exp_q.push_back(1'b0);
    rsp_exp_q.push_back(1'b1);
    rsp_exp_q.push_back(1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_DELAY; cmd_period = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) cmd_valid = 1'b0;
      e = rsp_exp_q.pop_front();
      checks++;
      if (rsp_valid !== e) begin
        failures++; $display("FAIL b2b_cycle%0d got=%b exp=%b", i, rsp_valid, e);
      end
    end
  endtask

  task automatic test_abort();
    int cyc;
    txn_t o, e;
    obs_q.delete();
    exp_q.push_back(wr_t(3'd2, 16'h03E8));
    exp_q.push_back(wr_t(3'd3, 16'h0000));
    exp_q.push_back(wr_t(3'd1, 16'h0004));
    exp_q.push_back(rd_t(3'd0));
    exp_q.push_back(wr_t(3'd1, 16'h0008));
    send(OP_DELAY, 32'd1000);          // now in cycle 1 (WR_PL)
    repeat (10) @(negedge clk);        // cycle 11: second GAP
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_rsp(50, cyc);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_status !== RSP_ABORT || rsp_data !== 32'd1) begin
      failures++;
      $display("FAIL abort_rsp got=%b/%0d/%0d exp=1/2/1", rsp_valid, rsp_status, rsp_data);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      checks++;
      if (o !== e) begin failures++; $display("FAIL abort_bus got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++; $display("FAIL abort_extra got=%0d exp=0", obs_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    int cyc;
    txn_t o, e;
    obs_wd_q.delete();
    exp_q.push_back(wr_t(3'd2, 16'h0000));
    exp_q.push_back(wr_t(3'd3, 16'h0001));
    exp_q.push_back(wr_t(3'd1, 16'h0004));
    for (int i = 0; i < 3; i++) exp_q.push_back(rd_t(3'd0));
    exp_q.push_back(wr_t(3'd1, 16'h0008));
    @(negedge clk);
    wd_cmd_valid = 1'b1; wd_cmd_op = OP_DELAY; wd_cmd_period = 32'h0001_0000;
    @(negedge clk);
    wd_cmd_valid = 1'b0;
    cyc = 1;
    while (wd_rsp_valid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    checks++;
    if (wd_rsp_valid !== 1'b1 || wd_rsp_status !== RSP_WDOG || wd_rsp_data !== 32'd3) begin
      failures++;
      $display("FAIL wdog_rsp got=%b/%0d/%0d exp=1/1/3", wd_rsp_valid, wd_rsp_status, wd_rsp_data);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_wd_q.size() > 0) ? obs_wd_q.pop_front() : '1;
      checks++;
      if (o !== e) begin failures++; $display("FAIL wdog_bus got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_wd_q.size() != 0) begin
      failures++; $display("FAIL wdog_extra got=%0d exp=0", obs_wd_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    obs_q.delete();
    send(OP_DELAY, 32'd100);
    repeat (2) @(negedge clk);         // cycle 3: WR_CTRL
    checks++;
    if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_address} !== {1'b1, 1'b0, 3'd1}) begin
      failures++;
      $display("FAIL rstmid_wrctrl got=%b%b%0d exp=101", bus.avm_chipselect, bus.avm_write_n,
               bus.avm_address);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus.avm_chipselect, bus.avm_write_n, cmd_ready, rsp_valid} !== 4'b0110) begin
      failures++;
      $display("FAIL rstmid_async got=%b%b%b%b exp=0110", bus.avm_chipselect, bus.avm_write_n,
               cmd_ready, rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (obs_q.size() != 2) begin
      failures++; $display("FAIL rstmid_traffic got=%0d exp=2", obs_q.size());
    end
    send(OP_SNAP, 32'd0);
    wait_rsp(50, cyc);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h00AB_CDEF || rsp_status !== RSP_OK || cyc != 6) begin
      failures++;
      $display("FAIL rstmid_snap got=%b/%h/%0d/%0d exp=1/00abcdef/0/6", rsp_valid, rsp_data,
               rsp_status, cyc);
    end
    @(negedge clk);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_period = '0; abort = 1'b0;
    wd_cmd_valid = 1'b0; wd_cmd_op = 1'b0; wd_cmd_period = '0; wd_abort = 1'b0;
    test_reset();
    test_delay();
    test_snapshot();
    test_period_zero();
    test_back_to_back();
    test_abort();
    test_watchdog();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
